// File: rtl/counter_sequencer.sv
// Command-driven stimulus and self-check engine for an up/down counter's pin interface.
// Drives load/enable/up_down/data_in from queued-by-source commands and shadows the counter.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             chk_en,
  output logic             load,
  output logic             enable,
  output logic             up_down,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] exp_val,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got
);

  typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_e;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic             load_q, enable_q, up_down_q, busy_q, done_q;
  logic [WIDTH-1:0] data_in_q;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_q;
  logic [ERRW-1:0]  err_cnt_q;
  logic [WIDTH-1:0] err_exp_q, err_got_q;
  logic             mismatch;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + ERRW'(1);
  endfunction

  function automatic logic [WIDTH-1:0] shadow_step(input logic [WIDTH-1:0] v,
                                                   input logic ld, input logic en,
                                                   input logic up, input logic [WIDTH-1:0] din);
    if (ld)      return din;
    else if (en) return up ? v + WIDTH'(1) : v - WIDTH'(1);
    else         return v;
  endfunction

  // rem_q counts steps still to issue, including the one currently on the pins
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      load_q    <= 1'b0;
      enable_q  <= 1'b0;
      up_down_q <= 1'b0;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            if (cmd_op == OP_LOAD) begin
              load_q    <= 1'b1;
              data_in_q <= cmd_arg;
              rem_q     <= WIDTH'(1);
              done_q    <= 1'b1;
            end else begin
              enable_q  <= (cmd_op != 2'b11) && (cmd_arg != '0);
              up_down_q <= (cmd_op == OP_UP) && (cmd_arg != '0);
              rem_q     <= cmd_arg;
              done_q    <= (cmd_arg <= WIDTH'(1));
            end
          end
        end
        RUN: begin
          if (rem_q <= WIDTH'(1)) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            load_q    <= 1'b0;
            enable_q  <= 1'b0;
            up_down_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
          end else begin
            rem_q  <= rem_q - WIDTH'(1);
            done_q <= (rem_q == WIDTH'(2));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exp_d    = shadow_step(exp_q, load_q, enable_q, up_down_q, data_in_q);
  assign mismatch = chk_en && (data_out != exp_q);

  // Shadow model advances with the counter; errors only accumulate while checking is enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      err_exp_q <= '0;
      err_got_q <= '0;
    end else begin
      exp_q <= exp_d;
      if (mismatch) begin
        err_q     <= 1'b1;
        err_cnt_q <= sat_inc(err_cnt_q);
        if (!err_q) begin
          err_exp_q <= exp_q;
          err_got_q <= data_out;
        end
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign load      = load_q;
  assign enable    = enable_q;
  assign up_down   = up_down_q;
  assign data_in   = data_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign exp_val   = exp_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;

endmodule
